// File: rtl/if_id_queue_pkg.sv
// Shared constants and types for the IF->ID instruction queue.
package if_id_queue_pkg;

  localparam int unsigned IFQ_DEPTH = 4;
  localparam int unsigned REG_BUS   = 32;
  localparam int unsigned STALL_ID  = 2;

  typedef enum logic [1:0] {
    ISSUE_HOLD,
    ISSUE_HEAD,
    ISSUE_BYPASS,
    ISSUE_BUBBLE
  } ifq_issue_e;

endpackage

// File: rtl/if_id_queue_if.sv
// IF-side enqueue and ID-side issue signals of the instruction queue.
interface if_id_queue_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic             if_valid;
  logic             if_ready;
  logic [WIDTH-1:0] if_pc;
  logic [WIDTH-1:0] if_inst;
  logic [WIDTH-1:0] if_exceptions;
  logic             id_valid;
  logic [WIDTH-1:0] id_pc;
  logic [WIDTH-1:0] id_inst;
  logic [WIDTH-1:0] id_exceptions;
  logic [PTR_W:0]   ifq_count;

  modport master (
    output if_valid, if_pc, if_inst, if_exceptions,
    input  if_ready, id_valid, id_pc, id_inst, id_exceptions, ifq_count
  );

  modport slave (
    input  if_valid, if_pc, if_inst, if_exceptions,
    output if_ready, id_valid, id_pc, id_inst, id_exceptions, ifq_count
  );
endinterface

// File: rtl/if_id_queue_fifo_mem.sv
// ifq_fifo_mem: DEPTH-entry storage with synchronous write, asynchronous head read.
module ifq_fifo_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 96,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           wr_en,
  input  logic [DW-1:0]  wr_data,
  input  logic           rd_en,
  output logic [DW-1:0]  rd_data,
  output logic [PTR_W:0] count,
  output logic           full,
  output logic           empty
);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Callers gate wr_en with !full and rd_en with !empty.
  always_ff @(posedge clk) begin
    if (rst == 1'b0 || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry instruction queue between IF and ID with a registered ID output.
// Optional same-cycle bypass into the ID register when empty: define IFQ_BYPASS_EN.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH,
  parameter int unsigned WIDTH = REG_BUS,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic [5:0] stall,
  if_id_queue_if.slave bus
);
  localparam int unsigned DW = 3 * WIDTH;

  logic             enq;
  logic             full;
  logic             empty;
  logic             wr_en;
  logic             rd_en;
  logic             bypass_ok;
  logic [WIDTH-1:0] nop_inst;
  logic [DW-1:0]    wr_data;
  logic [DW-1:0]    rd_data;
  logic [PTR_W:0]   count;
  ifq_issue_e       sel;
  logic             unused_stall;

  assign unused_stall = ^{stall[5:3], stall[1:0]};

  assign enq      = bus.if_valid && bus.if_ready && !flush;
  assign nop_inst = (bus.if_exceptions != '0 || bus.if_pc == '0) ? '0 : bus.if_inst;
  assign wr_data  = {bus.if_pc, nop_inst, bus.if_exceptions};

`ifdef IFQ_BYPASS_EN
  assign bypass_ok = enq;
`else
  assign bypass_ok = 1'b0;
`endif

  always_comb begin
    sel = ISSUE_HOLD;
    if (!stall[STALL_ID]) begin
      if (!empty)         sel = ISSUE_HEAD;
      else if (bypass_ok) sel = ISSUE_BYPASS;
      else                sel = ISSUE_BUBBLE;
    end
  end

  // A bypassed entry goes straight to ID and never occupies storage.
  assign wr_en = enq && (sel != ISSUE_BYPASS);
  assign rd_en = (sel == ISSUE_HEAD) && !flush;

  ifq_fifo_mem #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign bus.if_ready  = !full;
  assign bus.ifq_count = count;

  always_ff @(posedge clk) begin
    if (rst == 1'b0 || flush) begin
      bus.id_valid      <= 1'b0;
      bus.id_pc         <= '0;
      bus.id_inst       <= '0;
      bus.id_exceptions <= '0;
    end else begin
      unique case (sel)
        ISSUE_HEAD: begin
          bus.id_valid <= 1'b1;
          {bus.id_pc, bus.id_inst, bus.id_exceptions} <= rd_data;
        end
        ISSUE_BYPASS: begin
          bus.id_valid <= 1'b1;
          {bus.id_pc, bus.id_inst, bus.id_exceptions} <= wr_data;
        end
        ISSUE_BUBBLE: begin
          bus.id_valid      <= 1'b0;
          bus.id_pc         <= '0;
          bus.id_inst       <= '0;
          bus.id_exceptions <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue; expectations follow IFQ_BYPASS_EN.
module tb_if_id_queue;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [5:0] stall = '0;
  int unsigned total = 0;
  int unsigned bad = 0;

  if_id_queue_if #(.WIDTH(32), .DEPTH(4)) bus ();

  if_id_queue #(.DEPTH(4), .WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .stall (stall),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] exc);
    bus.if_valid      = 1'b1;
    bus.if_pc         = pc;
    bus.if_inst       = inst;
    bus.if_exceptions = exc;
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] inst, input logic [31:0] exc);
    chk({tag, "_valid"}, {31'b0, bus.id_valid}, {31'b0, v});
    chk({tag, "_pc"}, bus.id_pc, pc);
    chk({tag, "_inst"}, bus.id_inst, inst);
    chk({tag, "_exc"}, bus.id_exceptions, exc);
  endtask

  initial begin
    bus.if_valid      = 1'b0;
    bus.if_pc         = '0;
    bus.if_inst       = '0;
    bus.if_exceptions = '0;

    // Reset held for two cycles
    tick();
    tick();
    chk_id("reset", 1'b0, 32'h0, 32'h0, 32'h0);
    chk("reset_count", {29'b0, bus.ifq_count}, 32'd0);
    chk("reset_ready", {31'b0, bus.if_ready}, 32'd1);
    rst = 1'b1;

    // Single push into an empty queue
    push(32'h8000_0000, 32'h2408_0001, 32'h0);
    tick();
    bus.if_valid = 1'b0;
`ifdef IFQ_BYPASS_EN
    chk_id("byp_issue", 1'b1, 32'h8000_0000, 32'h2408_0001, 32'h0);
    chk("byp_count", {29'b0, bus.ifq_count}, 32'd0);
`else
    chk("lat1_valid", {31'b0, bus.id_valid}, 32'd0);
    chk("lat1_count", {29'b0, bus.ifq_count}, 32'd1);
    tick();
    chk_id("lat2_issue", 1'b1, 32'h8000_0000, 32'h2408_0001, 32'h0);
    chk("lat2_count", {29'b0, bus.ifq_count}, 32'd0);
`endif
    tick();
    chk_id("bubble0", 1'b0, 32'h0, 32'h0, 32'h0);

    // Fill under stall; the fifth entry is refused
    stall = 6'b000100;
    for (int i = 0; i < 5; i++) begin
      push(32'h100 + 32'(i) * 4, 32'h11 * 32'(i + 1), 32'h0);
      tick();
      if (i == 3) begin
        chk("full_count", {29'b0, bus.ifq_count}, 32'd4);
        chk("full_ready", {31'b0, bus.if_ready}, 32'd0);
      end
    end
    chk("fifth_count", {29'b0, bus.ifq_count}, 32'd4);
    chk_id("stall_hold", 1'b0, 32'h0, 32'h0, 32'h0);
    bus.if_valid = 1'b0;
    stall = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_pc", bus.id_pc, 32'h100 + 32'(i) * 4);
      chk("drain_inst", bus.id_inst, 32'h11 * 32'(i + 1));
      chk("drain_count", {29'b0, bus.ifq_count}, 32'(3 - i));
    end
    tick();
    chk_id("bubble1", 1'b0, 32'h0, 32'h0, 32'h0);

    // NOP forcing on exceptions and on pc==0
    push(32'h8000_0010, 32'h1234_5678, 32'h0000_0004);
    tick();
    push(32'h0, 32'hFFFF_FFFF, 32'h0);
`ifdef IFQ_BYPASS_EN
    chk_id("exc_nop", 1'b1, 32'h8000_0010, 32'h0, 32'h4);
    tick();
    bus.if_valid = 1'b0;
`else
    tick();
    bus.if_valid = 1'b0;
    chk_id("exc_nop", 1'b1, 32'h8000_0010, 32'h0, 32'h4);
    chk("pushpop_count", {29'b0, bus.ifq_count}, 32'd1);
    tick();
`endif
    chk_id("pc0_nop", 1'b1, 32'h0, 32'h0, 32'h0);
    chk("pc0_count", {29'b0, bus.ifq_count}, 32'd0);

    // Flush mid-stall with three queued entries and an entry on IF
    stall = 6'b000100;
    for (int i = 0; i < 3; i++) begin
      push(32'h200 + 32'(i) * 4, 32'hA0 + 32'(i), 32'h0);
      tick();
    end
    chk("preflush_count", {29'b0, bus.ifq_count}, 32'd3);
    flush = 1'b1;
    push(32'hDEAD_0000, 32'h99, 32'h0);
    tick();
    flush = 1'b0;
    bus.if_valid = 1'b0;
    chk_id("flush", 1'b0, 32'h0, 32'h0, 32'h0);
    chk("flush_count", {29'b0, bus.ifq_count}, 32'd0);
    chk("flush_ready", {31'b0, bus.if_ready}, 32'd1);
    stall = '0;
    tick();
    tick();
    chk_id("postflush", 1'b0, 32'h0, 32'h0, 32'h0);
    chk("postflush_count", {29'b0, bus.ifq_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
